// File: rtl/irq_ctrl.sv
// Interrupt controller: per-line mask and edge/level select, priority pick, and the
// take/return handshake with the CPU. Define IRQ_CTRL_ROTATE_EN for round-robin priority.
module irq_ctrl #(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_lines,
  input  logic               cpu_irq_en,
  output logic               irq_out,
  input  logic [1:0]         reg_sel,
  input  logic               reg_we,
  input  logic [15:0]        reg_wdata,
  output logic [15:0]        reg_rdata
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_REQ      = 2'd1;
  localparam logic [1:0] ST_SERVICE  = 2'd2;
  localparam logic [1:0] ST_WAIT_RET = 2'd3;

  localparam logic [1:0] REG_PENDING = 2'd0;
  localparam logic [1:0] REG_MASK    = 2'd1;
  localparam logic [1:0] REG_ACTIVE  = 2'd2;
  localparam logic [1:0] REG_EDGE    = 2'd3;

  logic [NUM_IRQ-1:0] mask_reg;
  logic [NUM_IRQ-1:0] edge_reg;
  logic [NUM_IRQ-1:0] edge_latch_reg;
  logic [NUM_IRQ-1:0] latch_next;
  logic [NUM_IRQ-1:0] prev_lines_reg;
  logic [1:0]         state_reg;
  logic [ID_W-1:0]    cur_id_reg;
  logic [ID_W-1:0]    active_id_reg;
  logic               active_valid_reg;
  logic               irq_out_reg;

  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] cur_onehot;
  logic [NUM_IRQ-1:0] w1c_bits;
  logic [NUM_IRQ-1:0] take_clr;
  logic [ID_W-1:0]    winner_id;
  logic               any_eligible;
  logic               cur_eligible;
  logic               take;
  logic [15:0]        active_word;
  logic               unused_wdata;

`ifdef IRQ_CTRL_ROTATE_EN
  logic [ID_W-1:0]    ptr_reg;
  logic [ID_W-1:0]    upper_id;
  logic               upper_found;
`endif

  assign unused_wdata = ^reg_wdata[15:NUM_IRQ];

  assign w1c_bits = (reg_we && reg_sel == REG_PENDING) ? reg_wdata[NUM_IRQ-1:0] : '0;
  assign take     = (state_reg == ST_REQ) && cpu_irq_en;
  assign take_clr = {NUM_IRQ{take}} & cur_onehot;

  // Per-line pending view and edge latch; a rising edge beats any clear in the same cycle.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_IRQ; gi++) begin : g_line
      assign pending[gi]    = edge_reg[gi] ? edge_latch_reg[gi] : irq_lines[gi];
      assign cur_onehot[gi] = (cur_id_reg == ID_W'(gi));
      assign latch_next[gi] = (edge_reg[gi] & irq_lines[gi] & ~prev_lines_reg[gi])
                            | (edge_latch_reg[gi] & ~(edge_reg[gi] & (w1c_bits[gi] | take_clr[gi])));
    end
  endgenerate

  assign eligible     = pending & mask_reg;
  assign any_eligible = |eligible;
  assign cur_eligible = |(eligible & cur_onehot);

  always_comb begin
    winner_id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) winner_id = ID_W'(i);
    end
`ifdef IRQ_CTRL_ROTATE_EN
    // Prefer the lowest eligible index at or above ptr; otherwise wrap to the lowest overall.
    upper_id    = '0;
    upper_found = 1'b0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i] && (ID_W'(i) >= ptr_reg)) begin
        upper_id    = ID_W'(i);
        upper_found = 1'b1;
      end
    end
    if (upper_found) winner_id = upper_id;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_reg         <= '0;
      edge_reg         <= '0;
      edge_latch_reg   <= '0;
      prev_lines_reg   <= '0;
      state_reg        <= ST_IDLE;
      cur_id_reg       <= '0;
      active_id_reg    <= '0;
      active_valid_reg <= 1'b0;
      irq_out_reg      <= 1'b0;
    end else begin
      prev_lines_reg <= irq_lines;
      edge_latch_reg <= latch_next;
      if (reg_we && reg_sel == REG_MASK) mask_reg <= reg_wdata[NUM_IRQ-1:0];
      if (reg_we && reg_sel == REG_EDGE) edge_reg <= reg_wdata[NUM_IRQ-1:0];

      case (state_reg)
        ST_IDLE: begin
          if (any_eligible) begin
            state_reg   <= ST_REQ;
            cur_id_reg  <= winner_id;
            irq_out_reg <= 1'b1;
          end
        end
        ST_REQ: begin
          if (cpu_irq_en) begin
            active_valid_reg <= 1'b1;
            active_id_reg    <= cur_id_reg;
            irq_out_reg      <= 1'b0;
            state_reg        <= ST_SERVICE;
          end else if (!cur_eligible) begin
            irq_out_reg <= 1'b0;
            state_reg   <= ST_IDLE;
          end
        end
        ST_SERVICE: begin
          if (!cpu_irq_en) state_reg <= ST_WAIT_RET;
        end
        ST_WAIT_RET: begin
          if (cpu_irq_en) begin
            state_reg        <= ST_IDLE;
            active_valid_reg <= 1'b0;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

`ifdef IRQ_CTRL_ROTATE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg <= '0;
    end else if (take) begin
      ptr_reg <= (cur_id_reg == ID_W'(NUM_IRQ - 1)) ? '0 : cur_id_reg + ID_W'(1);
    end
  end
`endif

  assign irq_out = irq_out_reg;

  always_comb begin
    active_word                = '0;
    active_word[15]            = active_valid_reg;
    active_word[ID_W-1:0]      = active_id_reg;
`ifdef IRQ_CTRL_ROTATE_EN
    active_word[8 +: ID_W]     = ptr_reg;
`endif
  end

  always_comb begin
    reg_rdata = '0;
    case (reg_sel)
      REG_PENDING: reg_rdata[NUM_IRQ-1:0] = pending;
      REG_MASK:    reg_rdata[NUM_IRQ-1:0] = mask_reg;
      REG_ACTIVE:  reg_rdata              = active_word;
      REG_EDGE:    reg_rdata[NUM_IRQ-1:0] = edge_reg;
      default:     reg_rdata              = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed handshake scenarios plus randomized traffic
// compared against a cycle-level behavioural model.
module tb_irq_ctrl;

  localparam int N  = 8;
  localparam int IW = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] irq_lines;
  logic         cpu_irq_en;
  logic         irq_out;
  logic [1:0]   reg_sel;
  logic         reg_we;
  logic [15:0]  reg_wdata;
  logic [15:0]  reg_rdata;

  int vectors = 0;
  int miscompares = 0;

  irq_ctrl #(.NUM_IRQ(N), .ID_W(IW)) dut (
    .clk(clk), .rst(rst), .irq_lines(irq_lines), .cpu_irq_en(cpu_irq_en),
    .irq_out(irq_out), .reg_sel(reg_sel), .reg_we(reg_we),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural model: handshake phase as an integer, per-line bits as plain vectors.
  localparam int P_IDLE = 0, P_REQ = 1, P_SVC = 2, P_RET = 3;
  bit [N-1:0] m_mask, m_edge, m_latch, m_prev;
  bit         m_valid;
  int         m_id, m_cur, m_phase, m_ptr;

  function automatic bit [N-1:0] m_pending(input logic [N-1:0] lines);
    bit [N-1:0] p;
    for (int i = 0; i < N; i++) p[i] = m_edge[i] ? m_latch[i] : lines[i];
    return p;
  endfunction

  function automatic int m_winner(input bit [N-1:0] elig);
    int start;
    start = 0;
`ifdef IRQ_CTRL_ROTATE_EN
    start = m_ptr;
`endif
    for (int k = 0; k < N; k++) begin
      if (elig[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [15:0] m_read(input logic [1:0] sel, input logic [N-1:0] lines);
    logic [15:0] r;
    r = '0;
    case (sel)
      2'd0: r[N-1:0] = m_pending(lines);
      2'd1: r[N-1:0] = m_mask;
      2'd2: begin
        r[15] = m_valid;
        r[IW-1:0] = IW'(m_id);
`ifdef IRQ_CTRL_ROTATE_EN
        r[14:8] = 7'(m_ptr);
`endif
      end
      default: r[N-1:0] = m_edge;
    endcase
    return r;
  endfunction

  always @(posedge clk) begin : model_update
    bit [N-1:0] elig, rise, w1c, nlatch;
    int w;
    if (rst) begin
      m_mask = '0; m_edge = '0; m_latch = '0; m_prev = '0;
      m_valid = 1'b0; m_id = 0; m_cur = 0; m_phase = P_IDLE; m_ptr = 0;
    end else begin
      elig   = m_pending(irq_lines) & m_mask;
      rise   = irq_lines & ~m_prev;
      w1c    = (reg_we && reg_sel == 2'd0) ? reg_wdata[N-1:0] : '0;
      nlatch = m_latch & ~(w1c & m_edge);
      case (m_phase)
        P_IDLE: begin
          w = m_winner(elig);
          if (w >= 0) begin m_cur = w; m_phase = P_REQ; end
        end
        P_REQ: begin
          if (cpu_irq_en) begin
            m_valid = 1'b1;
            m_id = m_cur;
            if (m_edge[m_cur]) nlatch[m_cur] = 1'b0;
            m_ptr = (m_cur + 1) % N;
            m_phase = P_SVC;
          end else if (!elig[m_cur]) begin
            m_phase = P_IDLE;
          end
        end
        P_SVC: if (!cpu_irq_en) m_phase = P_RET;
        default: if (cpu_irq_en) begin m_phase = P_IDLE; m_valid = 1'b0; end
      endcase
      nlatch  = nlatch | (rise & m_edge);
      m_latch = nlatch;
      m_prev  = irq_lines;
      if (reg_we && reg_sel == 2'd1) m_mask = reg_wdata[N-1:0];
      if (reg_we && reg_sel == 2'd3) m_edge = reg_wdata[N-1:0];
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] sel, input logic [15:0] data);
    reg_sel = sel; reg_wdata = data; reg_we = 1'b1;
    tick();
    reg_we = 1'b0;
  endtask

  task automatic do_reset();
    irq_lines = '0; cpu_irq_en = 1'b0; reg_we = 1'b0; reg_sel = 2'd0; reg_wdata = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (irq_out !== 1'b0) begin
      $display("FAIL reset_irq_out got=%b exp=0", irq_out); miscompares++;
    end
    for (int s = 0; s < 4; s++) begin
      reg_sel = 2'(s); #1;
      vectors++;
      if (reg_rdata !== 16'h0000) begin
        $display("FAIL reset_reg%0d got=%h exp=0000", s, reg_rdata); miscompares++;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_single_take();
    logic [15:0] exp;
    do_reset();
    wr(2'd1, 16'h00FF);
    wr(2'd3, 16'h0000);
    cpu_irq_en = 1'b1;
    irq_lines = 8'h08;
    tick();
    vectors++;
    if (irq_out !== 1'b1) begin
      $display("FAIL take_raise got=%b exp=1", irq_out); miscompares++;
    end
    tick();
    vectors++;
    if (irq_out !== 1'b0) begin
      $display("FAIL take_one_cycle got=%b exp=0", irq_out); miscompares++;
    end
    irq_lines = '0; reg_sel = 2'd2; #1;
    exp = 16'h8003;
`ifdef IRQ_CTRL_ROTATE_EN
    exp[14:8] = 7'd4;
`endif
    vectors++;
    if (reg_rdata !== exp) begin
      $display("FAIL take_active got=%h exp=%h", reg_rdata, exp); miscompares++;
    end
    @(negedge clk);
    cpu_irq_en = 1'b0; tick();
    cpu_irq_en = 1'b1; tick();
    exp[15] = 1'b0;
    vectors++;
    if (reg_rdata !== exp) begin
      $display("FAIL return_active got=%h exp=%h", reg_rdata, exp); miscompares++;
    end
  endtask

  task automatic test_priority();
    logic [15:0] exp;
    do_reset();
    wr(2'd1, 16'h00FF);
    cpu_irq_en = 1'b1;
    irq_lines = 8'h24;
    tick(); tick();
    reg_sel = 2'd2; #1;
    exp = 16'h8002;
`ifdef IRQ_CTRL_ROTATE_EN
    exp[14:8] = 7'd3;
`endif
    vectors++;
    if (reg_rdata !== exp) begin
      $display("FAIL prio_first got=%h exp=%h", reg_rdata, exp); miscompares++;
    end
    @(negedge clk);
    irq_lines = 8'h20;
    cpu_irq_en = 1'b0; tick();
    cpu_irq_en = 1'b1; tick();
    tick();
    vectors++;
    if (irq_out !== 1'b1) begin
      $display("FAIL prio_second_req got=%b exp=1", irq_out); miscompares++;
    end
    tick();
    exp = 16'h8005;
`ifdef IRQ_CTRL_ROTATE_EN
    exp[14:8] = 7'd6;
`endif
    vectors++;
    if (reg_rdata !== exp) begin
      $display("FAIL prio_second got=%h exp=%h", reg_rdata, exp); miscompares++;
    end
    irq_lines = '0;
    cpu_irq_en = 1'b0; tick();
    cpu_irq_en = 1'b1; tick();
  endtask

  task automatic test_edge_mask();
    do_reset();
    wr(2'd3, 16'h0001);
    cpu_irq_en = 1'b1;
    irq_lines = 8'h01; tick();
    irq_lines = 8'h00; tick();
    reg_sel = 2'd0; #1;
    vectors++;
    if (reg_rdata !== 16'h0001) begin
      $display("FAIL edge_latched got=%h exp=0001", reg_rdata); miscompares++;
    end
    vectors++;
    if (irq_out !== 1'b0) begin
      $display("FAIL edge_masked_irq got=%b exp=0", irq_out); miscompares++;
    end
    @(negedge clk);
    wr(2'd1, 16'h0001);
    tick();
    vectors++;
    if (irq_out !== 1'b1) begin
      $display("FAIL edge_req got=%b exp=1", irq_out); miscompares++;
    end
    tick();
    reg_sel = 2'd0; #1;
    vectors++;
    if (reg_rdata !== 16'h0000) begin
      $display("FAIL edge_take_clear got=%h exp=0000", reg_rdata); miscompares++;
    end
    @(negedge clk);
    cpu_irq_en = 1'b0; tick();
    cpu_irq_en = 1'b1; tick();
  endtask

  task automatic test_withdraw();
    do_reset();
    wr(2'd1, 16'h00FF);
    irq_lines = 8'h10;
    tick(); tick();
    vectors++;
    if (irq_out !== 1'b1) begin
      $display("FAIL withdraw_held got=%b exp=1", irq_out); miscompares++;
    end
    wr(2'd1, 16'h00EF);
    tick();
    vectors++;
    if (irq_out !== 1'b0) begin
      $display("FAIL withdraw_drop got=%b exp=0", irq_out); miscompares++;
    end
    tick();
    reg_sel = 2'd2; #1;
    vectors++;
    if (reg_rdata !== 16'h0000 || irq_out !== 1'b0) begin
      $display("FAIL withdraw_idle active=%h irq=%b exp=0000/0", reg_rdata, irq_out); miscompares++;
    end
    @(negedge clk);
    irq_lines = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    wr(2'd3, 16'h0002);
    wr(2'd1, 16'h0001);
    cpu_irq_en = 1'b1;
    irq_lines = 8'h03; tick();
    irq_lines = 8'h01; tick();
    reg_sel = 2'd0; #1;
    vectors++;
    if (reg_rdata !== 16'h0003) begin
      $display("FAIL mid_pending_before got=%h exp=0003", reg_rdata); miscompares++;
    end
    @(negedge clk);
    irq_lines = '0;
    rst = 1'b1; tick(); rst = 1'b0;
    vectors++;
    if (irq_out !== 1'b0) begin
      $display("FAIL mid_reset_irq got=%b exp=0", irq_out); miscompares++;
    end
    for (int s = 0; s < 4; s++) begin
      reg_sel = 2'(s); #1;
      vectors++;
      if (reg_rdata !== 16'h0000) begin
        $display("FAIL mid_reset_reg%0d got=%h exp=0000", s, reg_rdata); miscompares++;
      end
    end
    @(negedge clk);
    wr(2'd1, 16'h0001);
    irq_lines = 8'h01; tick();
    vectors++;
    if (irq_out !== 1'b1) begin
      $display("FAIL mid_idle_rereq got=%b exp=1", irq_out); miscompares++;
    end
    tick();
    irq_lines = '0;
    cpu_irq_en = 1'b0; tick();
    cpu_irq_en = 1'b1; tick();
  endtask

  task automatic test_arbitration_order();
    int exp_id[4];
    int exp_ptr[4];
    logic [15:0] exp;
`ifdef IRQ_CTRL_ROTATE_EN
    exp_id = '{1, 4, 1, 4}; exp_ptr = '{2, 5, 2, 5};
`else
    exp_id = '{1, 1, 1, 1}; exp_ptr = '{0, 0, 0, 0};
`endif
    do_reset();
    wr(2'd1, 16'h00FF);
    cpu_irq_en = 1'b1;
    irq_lines = 8'h12;
    for (int k = 0; k < 4; k++) begin
      tick(); tick();
      reg_sel = 2'd2; #1;
      exp = 16'h8000 | 16'(exp_ptr[k] << 8) | 16'(exp_id[k]);
      vectors++;
      if (reg_rdata !== exp) begin
        $display("FAIL order_%0d got=%h exp=%h", k, reg_rdata, exp); miscompares++;
      end
      @(negedge clk);
      cpu_irq_en = 1'b0; tick();
      cpu_irq_en = 1'b1; tick();
    end
    irq_lines = '0;
    tick();
  endtask

  task automatic test_random();
    logic [15:0] exp_rd;
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(3) == 0) irq_lines = N'($urandom);
      cpu_irq_en = ($urandom_range(2) != 0);
      reg_we     = ($urandom_range(7) == 0);
      reg_sel    = 2'($urandom);
      reg_wdata  = 16'($urandom);
      rst        = ($urandom_range(299) == 0);
      #1;
      exp_rd = m_read(reg_sel, irq_lines);
      vectors++;
      if (reg_rdata !== exp_rd) begin
        $display("FAIL rand_rdata cyc=%0d sel=%0d got=%h exp=%h", c, reg_sel, reg_rdata, exp_rd);
        miscompares++;
      end
      vectors++;
      if (irq_out !== (m_phase == P_REQ)) begin
        $display("FAIL rand_irq cyc=%0d got=%b exp=%b", c, irq_out, (m_phase == P_REQ));
        miscompares++;
      end
      tick();
    end
    rst = 1'b0; reg_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; irq_lines = '0; cpu_irq_en = 1'b0;
    reg_sel = 2'd0; reg_we = 1'b0; reg_wdata = '0;
    @(negedge clk);
    test_reset();
    test_single_take();
    test_priority();
    test_edge_mask();
    test_withdraw();
    test_reset_mid();
    test_arbitration_order();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
